sat_add_arbiter: RTL and testbench

//  Shares one N-bit saturating two's-complement adder among R requesters.
//  - Round-robin arbitration across requesters.
//  - Valid/ready handshake on both the request side and the result side.
//  - Single registered result slot, tagged with the winning requester's ID.

---
 rtl/sat_add_arbiter.sv | 149 ++++++++++++++
 tb/tb_sat_add_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter
//   Round-robin arbiter that shares one N-bit saturating two's-complement
//   adder among R requesters. Results go into a single registered slot that
//   is tagged with the winning requester's ID. The slot uses a valid/ready
//   handshake on the consumer side.
//   Optional feature: define SAT_ADD_STATS_EN to add the 16-bit ov_count
//   port. It counts accepted results that saturated, and it saturates at 16'hFFFF.
module sat_add_arbiter #(
    parameter int N   = 4,
    parameter int R   = 4,
    parameter int IDW = (R > 1) ? $clog2(R) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [R*N-1:0]   req_op1,
    input  logic [R*N-1:0]   req_op2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic [IDW-1:0]   res_id,
    output logic             res_ov,
`ifdef SAT_ADD_STATS_EN
    output logic [15:0]      ov_count,
`endif
    output logic             busy
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

    slot_t                 state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic signed [N-1:0]   res_data_q;
    logic [IDW-1:0]        res_id_q;
    logic                  res_ov_q;

    logic                  acc_en;
    logic                  any_valid;
    logic                  accept;
    logic [R-1:0]          rv_rot;
    logic [IDW-1:0]        gnt_off;
    logic [IDW-1:0]        gnt;
    logic [IDW:0]          gnt_sum;
    logic [IDW:0]          ptr_inc;
    logic signed [N-1:0]   op_a;
    logic signed [N-1:0]   op_b;
    logic signed [N-1:0]   sat_sum;
    logic                  sat_ov;

    // N-bit add with carry discarded; clamp to MIN/MAX on signed overflow.
    // Returns {ov, result}.
    function automatic logic [N:0] sat_add(input logic signed [N-1:0] a,
                                           input logic signed [N-1:0] b);
        logic signed [N-1:0] s;
        logic                ov;
        s  = a + b;
        ov = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
        if (ov) begin
            s = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
        return {ov, s};
    endfunction

    assign res_valid = (state_q == FULL);
    assign busy      = res_valid;
    assign acc_en    = !res_valid || res_ready;
    assign any_valid = |req_valid;
    assign accept    = acc_en && any_valid;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ov    = res_ov_q;

    // Round-robin grant: rotate the requests so ptr sits at bit 0, take the
    // lowest set bit, then map the offset back to an absolute index (mod R).
    always_comb begin
        rv_rot  = (req_valid >> ptr_q) | (req_valid << (R - int'(ptr_q)));
        gnt_off = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (rv_rot[k]) gnt_off = IDW'(k);
        end
        gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
        gnt     = (gnt_sum >= (IDW+1)'(R)) ? IDW'(gnt_sum - (IDW+1)'(R))
                                           : gnt_sum[IDW-1:0];
        ptr_inc = {1'b0, gnt} + (IDW+1)'(1);
        ptr_d   = ptr_q;
        if (accept) ptr_d = (ptr_inc >= (IDW+1)'(R)) ? '0 : ptr_inc[IDW-1:0];
        req_ready = '0;
        if (accept) req_ready[gnt] = 1'b1;
    end

    // Select the granted requester's operands and feed the shared adder.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < R; k++) begin
            if (gnt == IDW'(k)) begin
                op_a = req_op1[k*N +: N];
                op_b = req_op2[k*N +: N];
            end
        end
        {sat_ov, sat_sum} = sat_add(op_a, op_b);
    end

    // Slot next state: fill on accept, drain only when nothing new arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && res_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Slot state, round-robin pointer and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_ov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                res_data_q <= sat_sum;
                res_id_q   <= gnt;
                res_ov_q   <= sat_ov;
            end
        end
    end

`ifdef SAT_ADD_STATS_EN
    logic [15:0] ov_cnt_q;

    // Count accepted saturating results. The count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_cnt_q <= '0;
        end else if (accept && sat_ov && (ov_cnt_q != 16'hFFFF)) begin
            ov_cnt_q <= ov_cnt_q + 16'd1;
        end
    end

    assign ov_count = ov_cnt_q;
`endif

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Testbench for sat_add_arbiter (N=4, R=4). Expected results come from a
// reference model. They are pushed to a scoreboard queue when a grant is
// predicted, and compared while the result sits in the slot.
module tb_sat_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_op1;
    logic [15:0] req_op2;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ov;
    logic        busy;
`ifdef SAT_ADD_STATS_EN
    logic [15:0] ov_count;
`endif

    always #5 clk = ~clk;

    sat_add_arbiter #(.N(4), .R(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ov    (res_ov),
`ifdef SAT_ADD_STATS_EN
        .ov_count  (ov_count),
`endif
        .busy      (busy)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    logic [6:0] sb[$];          // {id, ov, data}
    int         m_ptr;
    logic       m_full;
    logic [3:0] exp_ready;
    logic       exp_acc;
    int         exp_g;
    logic [6:0] exp_entry;

    // Reference saturating add on true integer sum: returns {ov, data}.
    function automatic logic [4:0] model_sum(input logic [3:0] a, input logic [3:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 7)  return {1'b1, 4'h7};
        if (s < -8) return {1'b1, 4'h8};
        return {1'b0, s[3:0]};
    endfunction

    // Apply inputs for this cycle and predict the grant and result.
    task automatic drive(input logic [3:0] v, input logic [15:0] a,
                         input logic [15:0] b, input logic rr);
        logic [15:0] sa;
        logic [15:0] sb_op;
        int          idx;
        req_valid = v; req_op1 = a; req_op2 = b; res_ready = rr;
        exp_ready = '0; exp_acc = 1'b0; exp_g = 0; exp_entry = '0;
        if (!m_full || rr) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!exp_acc && v[idx[1:0]]) begin
                    exp_acc = 1'b1;
                    exp_g   = idx;
                end
            end
        end
        if (exp_acc) begin
            exp_ready[exp_g[1:0]] = 1'b1;
            sa    = a >> (4 * exp_g);
            sb_op = b >> (4 * exp_g);
            exp_entry = {exp_g[1:0], model_sum(sa[3:0], sb_op[3:0])};
        end
        #1;
    endtask

    // Clock edge: update model slot, pointer and scoreboard.
    task automatic advance();
        @(posedge clk);
        if (m_full && res_ready) void'(sb.pop_front());
        if (exp_acc) begin
            sb.push_back(exp_entry);
            m_ptr = (exp_g + 1) % 4;
        end
        m_full  = exp_acc || (m_full && !res_ready);
        exp_acc = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; res_ready = 1'b0;
        m_ptr = 0; m_full = 1'b0; exp_acc = 1'b0; sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; res_ready = 1'b0;
        m_ptr = 0; m_full = 1'b0; exp_acc = 1'b0; sb.delete();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({res_valid, busy, res_ov, res_id, res_data} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000000", {res_valid, busy, res_ov, res_id, res_data});
        end
        n_chk++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        drive(4'b0001, 16'h0003, 16'h0002, 1'b1);
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        advance();
        n_chk++;
        if ({res_valid, res_id, res_ov, res_data} !== {1'b1, 2'd0, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL single_result: got v=%b id=%0d ov=%b d=%h want v=1 id=0 ov=0 d=5",
                     res_valid, res_id, res_ov, res_data);
        end
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL single_rdy: got %b want %b", req_ready, exp_ready); end
        n_chk++; if (res_valid !== m_full || busy !== m_full) begin n_fail++; $display("FAIL single_valid: got %b/%b want %b", res_valid, busy, m_full); end
        if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL single_sb: got %h want %h", {res_id, res_ov, res_data}, sb[0]); end end
        advance();
        n_chk++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got res_valid=%b want 0", res_valid); end
    endtask

    task automatic test_saturation();
        logic [3:0] ta [4] = '{4'h7, 4'h8, 4'h8, 4'hF};
        logic [3:0] tb [4] = '{4'h1, 4'hF, 4'h7, 4'hF};
        logic [4:0] te [4] = '{5'h17, 5'h18, 5'h0F, 5'h0E};
        for (int i = 0; i < 4; i++) begin
            drive(4'b1111, {4{ta[i]}}, {4{tb[i]}}, 1'b1);
            n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL sat_rdy[%0d]: got %b want %b", i, req_ready, exp_ready); end
            n_chk++; if (res_valid !== m_full || busy !== m_full) begin n_fail++; $display("FAIL sat_valid[%0d]: got %b/%b want %b", i, res_valid, busy, m_full); end
            if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL sat_sb[%0d]: got %h want %h", i, {res_id, res_ov, res_data}, sb[0]); end end
            advance();
            n_chk++;
            if ({res_ov, res_data} !== te[i]) begin
                n_fail++; $display("FAIL sat_value[%0d]: got ov=%b d=%h want ov=%b d=%h", i, res_ov, res_data, te[i][4], te[i][3:0]);
            end
        end
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        advance();
    endtask

    task automatic test_fairness();
        logic [1:0] seq1 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] seq2 [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 16'h4321, 16'h1111, 1'b1);
            n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL fair_rdy[%0d]: got %b want %b", i, req_ready, exp_ready); end
            if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL fair_sb[%0d]: got %h want %h", i, {res_id, res_ov, res_data}, sb[0]); end end
            advance();
            n_chk++; if (res_id !== seq1[i]) begin n_fail++; $display("FAIL fair_seq1[%0d]: got id %0d want %0d", i, res_id, seq1[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'b1101, 16'h4321, 16'h1111, 1'b1);
            n_chk++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL fair2_rdy[%0d]: got %b want %b", i, req_ready, exp_ready); end
            if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL fair2_sb[%0d]: got %h want %h", i, {res_id, res_ov, res_data}, sb[0]); end end
            advance();
            n_chk++; if (res_id !== seq2[i]) begin n_fail++; $display("FAIL fair_seq2[%0d]: got id %0d want %0d", i, res_id, seq2[i]); end
        end
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        advance();
    endtask

    task automatic test_backpressure();
        drive(4'b1111, 16'h4321, 16'h1111, 1'b1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 16'h7654, 16'h2222, 1'b0);
            n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy[%0d]: got %b want 0000", i, req_ready); end
            n_chk++; if (res_valid !== m_full || busy !== m_full) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b/%b want %b", i, res_valid, busy, m_full); end
            if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {res_id, res_ov, res_data}, sb[0]); end end
            advance();
        end
        drive(4'b1111, 16'h7654, 16'h2222, 1'b1);
        n_chk++; if (req_ready !== exp_ready || exp_ready == 4'b0000) begin n_fail++; $display("FAIL bp_release_rdy: got %b want %b", req_ready, exp_ready); end
        if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL bp_release_sb: got %h want %h", {res_id, res_ov, res_data}, sb[0]); end end
        advance();
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        n_chk++; if (res_valid !== m_full) begin n_fail++; $display("FAIL bp_next_valid: got %b want %b", res_valid, m_full); end
        if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL bp_next_sb: got %h want %h", {res_id, res_ov, res_data}, sb[0]); end end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(4'b0010, 16'h0050, 16'h0010, 1'b1);
        advance();
        drive(4'b1111, 16'h1111, 16'h1111, 1'b0);
        n_chk++; if ({res_valid, res_id, res_data} !== {1'b1, 2'd1, 4'h6}) begin n_fail++; $display("FAIL rmid_pre: got v=%b id=%0d d=%h want v=1 id=1 d=6", res_valid, res_id, res_data); end
        advance();
        rst_n = 1'b0; req_valid = '0;
        m_ptr = 0; m_full = 1'b0; exp_acc = 1'b0; sb.delete();
        #1;
        n_chk++;
        if ({res_valid, busy, res_ov, res_id, res_data, req_ready} !== 13'b0) begin
            n_fail++; $display("FAIL rmid_async: got %b want all zero", {res_valid, busy, res_ov, res_id, res_data, req_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b1111, 16'h1111, 16'h2222, 1'b1);
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
        advance();
        n_chk++; if ({res_valid, res_id, res_data} !== {1'b1, 2'd0, 4'h3}) begin n_fail++; $display("FAIL rmid_result: got v=%b id=%0d d=%h want v=1 id=0 d=3", res_valid, res_id, res_data); end
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        advance();
    endtask

`ifdef SAT_ADD_STATS_EN
    task automatic test_stats();
        logic [3:0] ta [5] = '{4'h7, 4'h8, 4'h4, 4'h1, 4'h8};
        logic [3:0] tb [5] = '{4'h1, 4'hF, 4'h4, 4'h1, 4'h7};
        do_reset();
        n_chk++; if (ov_count !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %h want 0000", ov_count); end
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, {12'h0, ta[i]}, {12'h0, tb[i]}, 1'b1);
            if (m_full) begin n_chk++; if ({res_id, res_ov, res_data} !== sb[0]) begin n_fail++; $display("FAIL stats_sb[%0d]: got %h want %h", i, {res_id, res_ov, res_data}, sb[0]); end end
            advance();
        end
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        advance();
        n_chk++; if (ov_count !== 16'd3) begin n_fail++; $display("FAIL stats_count: got %0d want 3", ov_count); end
        for (int i = 0; i < 65532; i++) begin
            drive(4'b0001, 16'h0007, 16'h0001, 1'b1);
            advance();
        end
        n_chk++; if (ov_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_full: got %h want ffff", ov_count); end
        drive(4'b0001, 16'h0007, 16'h0001, 1'b1);
        advance();
        drive(4'b0000, 16'h0, 16'h0, 1'b1);
        advance();
        n_chk++; if (ov_count !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %h want ffff", ov_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef SAT_ADD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
